riscv_mem_arbiter: RTL and testbench

//  Shares one single-port memory between the RISC-V core's instruction-fetch port and data port.

---
 rtl/riscv_mem_pkg.sv | 7 +
 rtl/riscv_rr_arb2.sv | 25 ++
 rtl/riscv_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types for the core-to-unified-memory arbiter.
package riscv_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_e;
  typedef enum logic {GNT_INST, GNT_DATA} grant_e;

endpackage

// File: rtl/riscv_rr_arb2.sv
// Two-requester round-robin picker; purely combinational so it can front any shared resource.
// req[0] is the fetch side, req[1] the data side. grant is only meaningful when |req.
module riscv_rr_arb2
  import riscv_mem_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last_grant,
  output grant_e     grant
);

  always_comb begin
    grant = GNT_INST;
    case (req)
      2'b01: grant = GNT_INST;
      2'b10: grant = GNT_DATA;
      2'b11: begin
        // Under contention the side that did not win last time goes next.
        if (last_grant == GNT_DATA) grant = GNT_INST;
        else                        grant = GNT_DATA;
      end
      default: grant = GNT_INST;
    endcase
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Serialises fetch and data accesses onto one single-port memory with round-robin
// arbitration, registered handshakes on both sides and a watchdog abort on stalled accesses.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_IMEM_ADDR_WIDTH = 32,
  parameter int P_DMEM_ADDR_WIDTH = 32,
  parameter int P_TIMEOUT         = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inst_req,
  input  logic [P_IMEM_ADDR_WIDTH-1:0] inst_addr,
  output logic [P_DATA_WIDTH-1:0]      instr_data,
  output logic                         instr_ready,
  input  logic                         data_req,
  input  logic                         data_wr_en_ma,
  input  logic [P_DATA_WIDTH/8-1:0]    data_be,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] data_addr,
  input  logic [P_DATA_WIDTH-1:0]      data_wr,
  output logic [P_DATA_WIDTH-1:0]      data_rd,
  output logic                         data_ready,
  output logic                         bus_err,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [P_DATA_WIDTH/8-1:0]    mem_be,
  output logic [P_DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [P_DATA_WIDTH-1:0]      mem_wdata,
  input  logic [P_DATA_WIDTH-1:0]      mem_rdata,
  input  logic                         mem_ready
);

  localparam int TW = $clog2(P_TIMEOUT + 1);

  arb_state_e              state, state_nxt;
  grant_e                  last_grant, owner, pick;
  logic [TW-1:0]           timer;
  logic                    accept, done, expire;
  logic [P_DATA_WIDTH-1:0] rsp_word;

  riscv_rr_arb2 u_pick (
    .req        ({data_req, inst_req}),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (inst_req || data_req) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A completion in the last allowed cycle still wins over the abort.
        if (mem_ready) begin
          done      = 1'b1;
          state_nxt = RESP;
        end else if (timer == TW'(P_TIMEOUT - 1)) begin
          expire    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writes and aborted accesses return zero to the requester.
  assign rsp_word = (done && !mem_we) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GNT_DATA;
      owner       <= GNT_INST;
      timer       <= '0;
      instr_data  <= '0;
      instr_ready <= 1'b0;
      data_rd     <= '0;
      data_ready  <= 1'b0;
      bus_err     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_nxt;
      instr_ready <= 1'b0;
      data_ready  <= 1'b0;
      bus_err     <= 1'b0;

      if (accept) begin
        owner      <= pick;
        last_grant <= pick;
        timer      <= '0;
        mem_req    <= 1'b1;
        if (pick == GNT_INST) begin
          mem_we    <= 1'b0;
          mem_be    <= '1;
          mem_addr  <= P_DMEM_ADDR_WIDTH'(inst_addr);
          mem_wdata <= '0;
        end else begin
          mem_we    <= data_wr_en_ma;
          mem_be    <= data_wr_en_ma ? data_be : '1;
          mem_addr  <= data_addr;
          mem_wdata <= data_wr_en_ma ? data_wr : '0;
        end
      end

      if (state == WAIT && !done && !expire)
        timer <= timer + TW'(1);

      if (done || expire) begin
        mem_req <= 1'b0;
        bus_err <= expire;
        if (owner == GNT_INST) begin
          instr_ready <= 1'b1;
          instr_data  <= rsp_word;
        end else begin
          data_ready <= 1'b1;
          data_rd    <= rsp_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed and randomized checks of the fetch/data memory arbiter against a
// word-level memory model and per-side request/response expectations.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] instr_data;
  logic        instr_ready;
  logic        data_req;
  logic        data_wr_en_ma;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        data_ready;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int vectors = 0;
  int miscompares = 0;

  riscv_mem_arbiter #(.P_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .instr_data(instr_data), .instr_ready(instr_ready),
    .data_req(data_req), .data_wr_en_ma(data_wr_en_ma), .data_be(data_be), .data_addr(data_addr),
    .data_wr(data_wr), .data_rd(data_rd), .data_ready(data_ready), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory model driven by the DUT's memory port
  logic [31:0] ram [logic [31:0]];
  bit          hang = 0, stray = 0, rand_lat = 0, busy = 0;
  int          lat = 0, cur_lat = 0, wait_cnt = 0;
  logic [31:0] last_addr, last_wdata;
  logic        last_we;
  logic [3:0]  last_be;

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_word(a);
  endfunction

  initial begin
    logic [31:0] w;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (mem_req && !hang) begin
        if (!busy) begin
          busy = 1; wait_cnt = 0;
          cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
        end
        if (wait_cnt >= cur_lat) begin
          last_addr = mem_addr; last_we = mem_we; last_be = mem_be; last_wdata = mem_wdata;
          w = ram_rd(mem_addr);
          if (mem_we) begin
            for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            ram[mem_addr] = w;
            mem_rdata = 32'h5A5A_5A5A;
          end else begin
            check("read_be_all_ones", mem_be, 4'hF);
            mem_rdata = w;
          end
          mem_ready = 1'b1;
          busy = 0;
        end else wait_cnt++;
      end else if (!mem_req) begin
        busy = 0;
        if (stray) begin mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0; end
      end
    end
  end

  // Monitor: pulse counts, grant order, mutual exclusion of ready pulses
  int inst_pulses = 0, data_pulses = 0, memreq_cycles = 0;
  bit order_q[$];
  initial forever begin
    @(negedge clk);
    if (mem_req) memreq_cycles++;
    if (instr_ready) begin inst_pulses++; order_q.push_back(1'b0); end
    if (data_ready)  begin data_pulses++; order_q.push_back(1'b1); end
    if (instr_ready || data_ready) check("ready_exclusive", instr_ready && data_ready, 1'b0);
  end

  // Reference memory for the data side
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic wait_ready(input bit side, output logic [31:0] d, output logic e, output int n);
    n = 0; d = 'x; e = 'x;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (side ? data_ready : instr_ready) begin
        n = i; d = side ? data_rd : instr_data; e = bus_err;
        break;
      end
    end
    check(side ? "data_ready_seen" : "instr_ready_seen", n > 0, 1'b1);
    if (side) data_req = 1'b0; else inst_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] d, a, wd, exp;
    logic        e, we;
    logic [3:0]  be;
    int          n, p0;

    #1000000;
    $display("FAIL global_time_limit: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          n, p0;

    inst_req = 0; inst_addr = 0; data_req = 0; data_wr_en_ma = 0;
    data_be = 0; data_addr = 0; data_wr = 0;
    do_reset();

    // Reset state
    check("rst_mem_req", mem_req, 0);     check("rst_mem_we", mem_we, 0);
    check("rst_mem_be", mem_be, 0);       check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0); check("rst_instr_ready", instr_ready, 0);
    check("rst_data_ready", data_ready, 0); check("rst_bus_err", bus_err, 0);
    check("rst_instr_data", instr_data, 0); check("rst_data_rd", data_rd, 0);

    // 1: fetch, memory answers one cycle after mem_req
    @(posedge clk); #1;
    lat = 1; inst_addr = 32'h100; inst_req = 1;
    wait_ready(0, d, e, n);
    check("t1_latency", n, 3);
    check("t1_data", d, init_word(32'h100));
    check("t1_err", e, 0);
    check("t1_mem_addr", last_addr, 32'h100);
    check("t1_mem_we", last_we, 0);
    @(posedge clk); #1;
    check("t1_ready_one_cycle", instr_ready, 0);

    // 2: partial data write, then read back
    lat = 0;
    data_addr = 32'h2000; data_wr = 32'hDEAD_BEEF; data_be = 4'b0011; data_wr_en_ma = 1; data_req = 1;
    wait_ready(1, d, e, n);
    check("t2_latency", n, 2);
    check("t2_mem_we", last_we, 1);
    check("t2_mem_be", last_be, 4'b0011);
    check("t2_mem_wdata", last_wdata, 32'hDEAD_BEEF);
    check("t2_err", e, 0);
    check("t2_wr_rsp_zero", d, 0);
    data_wr_en_ma = 0; data_be = 4'b0000; data_req = 1;
    wait_ready(1, d, e, n);
    check("t2_readback", d, 32'hC0DE_BEEF);

    // 3: both requesting from reset, re-requesting at each ready
    reset = 1; inst_req = 1; inst_addr = 32'h300; data_req = 1; data_addr = 32'h400;
    data_wr_en_ma = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    order_q.delete();
    fork
      begin
        logic [31:0] fd; logic fe; int fn;
        for (int k = 0; k < 2; k++) begin
          inst_addr = 32'h300 + 32'(4 * k); inst_req = 1;
          wait_ready(0, fd, fe, fn);
          check("t3_fetch_data", fd, init_word(32'h300 + 32'(4 * k)));
        end
      end
      begin
        logic [31:0] dd; logic de; int dn;
        for (int k = 0; k < 2; k++) begin
          data_addr = 32'h400 + 32'(4 * k); data_req = 1;
          wait_ready(1, dd, de, dn);
          check("t3_data_data", dd, init_word(32'h400 + 32'(4 * k)));
        end
      end
    join
    repeat (2) @(posedge clk); #1;
    check("t3_order_len", order_q.size(), 4);
    if (order_q.size() == 4) begin
      check("t3_order0", order_q[0], 0); check("t3_order1", order_q[1], 1);
      check("t3_order2", order_q[2], 0); check("t3_order3", order_q[3], 1);
    end

    // 4: memory never answers -> abort after 8 cycles in WAIT
    hang = 1; memreq_cycles = 0;
    inst_addr = 32'h140; inst_req = 1;
    wait_ready(0, d, e, n);
    check("t4_latency", n, 9);
    check("t4_err", e, 1);
    check("t4_data_zero", d, 0);
    @(posedge clk); #1;
    check("t4_mem_req_cycles", memreq_cycles, 8);
    check("t4_err_cleared", bus_err, 0);

    // 5: reset while WAIT, held request served exactly once afterwards
    p0 = inst_pulses;
    inst_addr = 32'h180; inst_req = 1;
    repeat (2) @(posedge clk); #1;
    check("t5_in_wait", mem_req, 1);
    reset = 1; #1;
    check("t5_rst_mem_req", mem_req, 0);   check("t5_rst_mem_addr", mem_addr, 0);
    check("t5_rst_instr_data", instr_data, 0); check("t5_rst_ready", instr_ready, 0);
    @(posedge clk); #1;
    hang = 0; lat = 0; reset = 0;
    wait_ready(0, d, e, n);
    check("t5_latency", n, 2);
    check("t5_data", d, init_word(32'h180));
    repeat (5) @(posedge clk); #1;
    check("t5_single_pulse", inst_pulses - p0, 1);

    // 6: stray mem_ready in IDLE, request inputs changing during WAIT
    p0 = inst_pulses + data_pulses;
    stray = 1;
    repeat (3) begin
      @(posedge clk); #1;
      check("t6_idle_mem_req", mem_req, 0);
    end
    stray = 0;
    @(posedge clk); #1;
    check("t6_no_pulse", inst_pulses + data_pulses - p0, 0);
    lat = 4;
    data_addr = 32'h8100; data_wr_en_ma = 0; data_be = 4'h0; data_req = 1;
    @(posedge clk); #1;
    data_addr = 32'h8200; data_wr_en_ma = 1; data_wr = 32'h1234_5678; data_be = 4'h1;
    @(posedge clk); #1;
    check("t6_addr_held", mem_addr, 32'h8100);
    check("t6_we_held", mem_we, 0);
    check("t6_be_held", mem_be, 4'hF);
    data_wr_en_ma = 0;
    wait_ready(1, d, e, n);
    check("t6_data", d, init_word(32'h8100));
    check("t6_served_addr", last_addr, 32'h8100);

    // Randomized traffic from both sides with random memory latency
    rand_lat = 1;
    fork
      begin
        logic [31:0] fa, fd; logic fe; int fn;
        for (int k = 0; k < 20; k++) begin
          fa = 32'h1000 + 32'(4 * $urandom_range(0, 255));
          inst_addr = fa; inst_req = 1;
          wait_ready(0, fd, fe, fn);
          check("rnd_fetch_data", fd, init_word(fa));
          check("rnd_fetch_err", fe, 0);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
      begin
        logic [31:0] ra, rw, rd, rexp; logic rwe, re; logic [3:0] rbe; int rn;
        for (int k = 0; k < 20; k++) begin
          ra = 32'h8000 + 32'(4 * $urandom_range(0, 15));
          rwe = 1'($urandom_range(0, 1)); rbe = 4'($urandom); rw = $urandom;
          rexp = 32'h0;
          if (rwe) begin
            logic [31:0] m;
            m = ref_rd(ra);
            for (int b = 0; b < 4; b++) if (rbe[b]) m[8*b +: 8] = rw[8*b +: 8];
            ref_mem[ra] = m;
          end else rexp = ref_rd(ra);
          data_addr = ra; data_wr_en_ma = rwe; data_be = rbe; data_wr = rw; data_req = 1;
          wait_ready(1, rd, re, rn);
          check("rnd_data_rsp", rd, rexp);
          check("rnd_data_err", re, 0);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
    join

    repeat (3) @(posedge clk); #1;
    check("end_idle_mem_req", mem_req, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
